// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: timed pattern engine for the LED bank.
// A configuration arrives over a valid/ready handshake; the block then steps
// the LED register every `per` clocks in SOLID, BLINK, ROTL or ROTR mode,
// either for cfg_count steps (then a one-cycle done pulse) or forever.
// Optional feature macro: LED_SEQ_PAUSE_EN adds a `pause` input that freezes
// a run in place (counter, remaining steps and LEDs) while it is high.
module led_seq_ctrl #(
  parameter int unsigned CLK_DIV = 150000000,
  parameter int unsigned LED_W   = 16,
  parameter int unsigned CNT_W   = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_mode,
  input  logic [LED_W-1:0] cfg_pattern,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [7:0]       cfg_count,
`ifdef LED_SEQ_PAUSE_EN
  input  logic             pause,
`endif
  output logic [LED_W-1:0] led,
  output logic             busy,
  output logic             step_tick,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SOLID = 2'd0,
    BLINK = 2'd1,
    ROTL  = 2'd2,
    ROTR  = 2'd3
  } mode_t;

  localparam logic [CNT_W-1:0] DEF_PER = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  state_t           state;
  mode_t            mode;
  logic [LED_W-1:0] pattern;
  logic [CNT_W-1:0] per;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       steps_left;
  logic             finite;

  logic             accept;
  logic             hold;
  logic [CNT_W-1:0] cfg_per;
  logic [LED_W-1:0] led_next;

  // Pause source: the optional input, or permanently released.
`ifdef LED_SEQ_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  // Handshake: accept anywhere except the single DONE cycle.
  always_comb begin
    cfg_ready = (state != DONE);
    accept    = cfg_valid & cfg_ready;
    cfg_per   = (cfg_period == '0) ? DEF_PER : cfg_period;
  end

  // LED value produced by a step edge in the latched mode.
  always_comb begin
    led_next = led;
    unique case (mode)
      SOLID: led_next = led;
      BLINK: led_next = (led == '0) ? pattern : '0;
      ROTL:  led_next = {led[LED_W-2:0], led[LED_W-1]};
      ROTR:  led_next = {led[0], led[LED_W-1:1]};
      default: led_next = led;
    endcase
  end

  // Sequencer FSM with registered outputs; an accept overrides any step edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mode       <= SOLID;
      pattern    <= '0;
      per        <= '0;
      cnt        <= '0;
      steps_left <= '0;
      finite     <= 1'b0;
      led        <= '0;
      busy       <= 1'b0;
      step_tick  <= 1'b0;
      done       <= 1'b0;
    end else begin
      step_tick <= 1'b0;
      done      <= 1'b0;
      if (accept) begin
        mode       <= mode_t'(cfg_mode);
        pattern    <= cfg_pattern;
        per        <= cfg_per;
        cnt        <= cfg_per - ONE_CNT;
        steps_left <= cfg_count;
        finite     <= (cfg_count != 8'd0);
        led        <= cfg_pattern;
        busy       <= 1'b1;
        state      <= RUN;
      end else begin
        unique case (state)
          IDLE: begin
            busy <= 1'b0;
          end
          RUN: begin
            if (!hold) begin
              if (cnt != '0) begin
                cnt <= cnt - ONE_CNT;
              end else begin
                cnt       <= per - ONE_CNT;
                step_tick <= 1'b1;
                led       <= led_next;
                if (finite) begin
                  steps_left <= steps_left - 8'd1;
                  if (steps_left == 8'd1) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                  end
                end
              end
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl (CLK_DIV overridden to 10).
// Reference model predicts each cycle from elapsed run time since accept:
// step j happens after j*per running cycles, and the LED value is a closed
// form of (mode, pattern, j).
module tb_led_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_pattern;
  logic [27:0] cfg_period;
  logic [7:0]  cfg_count;
  logic        pause;
  logic [15:0] led;
  logic        busy;
  logic        step_tick;
  logic        done;

  int nvec = 0;
  int nerr = 0;

  led_seq_ctrl #(
    .CLK_DIV(10),
    .LED_W  (16),
    .CNT_W  (28)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_mode   (cfg_mode),
    .cfg_pattern(cfg_pattern),
    .cfg_period (cfg_period),
    .cfg_count  (cfg_count),
`ifdef LED_SEQ_PAUSE_EN
    .pause      (pause),
`endif
    .led        (led),
    .busy       (busy),
    .step_tick  (step_tick),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit          m_run;
  bit          m_indone;
  int          m_mode;
  logic [15:0] m_pat;
  longint      m_per;
  longint      m_n;
  longint      m_el;
  logic [15:0] m_led;
  bit          m_busy;
  bit          m_tick;
  bit          m_done;

  function automatic logic [15:0] led_after(int mode, logic [15:0] p, longint j);
    int r;
    logic [15:0] v;
    r = int'(j % 16);
    v = p;
    case (mode)
      0: v = p;
      1: v = (j % 2 == 1) ? 16'h0000 : p;
      2: v = (r == 0) ? p : ((p << r) | (p >> (16 - r)));
      3: v = (r == 0) ? p : ((p >> r) | (p << (16 - r)));
      default: v = p;
    endcase
    return v;
  endfunction

  task automatic model_edge();
    bit pz;
    pz = 1'b0;
`ifdef LED_SEQ_PAUSE_EN
    pz = pause;
`endif
    if (rst) begin
      m_run = 0; m_indone = 0; m_led = '0; m_busy = 0; m_tick = 0; m_done = 0;
    end else begin
      m_tick = 0;
      m_done = 0;
      if (m_indone) begin
        m_indone = 0;
      end else if (cfg_valid) begin
        m_mode = int'(cfg_mode);
        m_pat  = cfg_pattern;
        m_per  = (cfg_period == 0) ? 10 : longint'(cfg_period);
        m_n    = longint'(cfg_count);
        m_el   = 0;
        m_run  = 1;
        m_led  = cfg_pattern;
        m_busy = 1;
      end else if (m_run && !pz) begin
        m_el++;
        if (m_el % m_per == 0) begin
          m_tick = 1;
          m_led  = led_after(m_mode, m_pat, m_el / m_per);
          if (m_n != 0 && m_el / m_per == m_n) begin
            m_run = 0; m_indone = 1; m_done = 1; m_busy = 0;
          end
        end
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    chk("led", 32'(led), 32'(m_led));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("step_tick", 32'(step_tick), 32'(m_tick));
    chk("done", 32'(done), 32'(m_done));
    chk("cfg_ready", 32'(cfg_ready), 32'(!m_indone));
  endtask

  task automatic cycles(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic offer(int mode, logic [15:0] p, logic [27:0] per, logic [7:0] n);
    cfg_valid   = 1'b1;
    cfg_mode    = 2'(mode);
    cfg_pattern = p;
    cfg_period  = per;
    cfg_count   = n;
    cycle();
    cfg_valid   = 1'b0;
  endtask

  initial begin
    int ndone;
    rst = 1'b1; cfg_valid = 1'b0; cfg_mode = '0; cfg_pattern = '0;
    cfg_period = '0; cfg_count = '0; pause = 1'b0;
    m_run = 0; m_indone = 0; m_led = '0; m_busy = 0; m_tick = 0; m_done = 0;
    m_mode = 0; m_pat = '0; m_per = 1; m_n = 0; m_el = 0;

    // Reset
    cycles(3);
    chk("reset_led", 32'(led), 32'h0);
    rst = 1'b0;
    cycle();
    chk("ready_after_reset", 32'(cfg_ready), 32'h1);

    // ROTL finite run: steps at +4,+8,+12, done with the last step
    offer(2, 16'h0001, 28'd4, 8'd3);
    chk("rotl_first", 32'(led), 32'h0001);
    cycles(4);
    chk("rotl_step1", 32'({step_tick, led}), 32'h1_0002);
    cycles(8);
    chk("rotl_done", 32'({done, step_tick, led}), 32'h3_0008);
    cycles(3);
    chk("rotl_idle_hold", 32'({busy, led}), 32'h0_0008);

    // BLINK forever with default period (10)
    offer(1, 16'hA5A5, 28'd0, 8'd0);
    cycles(10);
    chk("blink_off", 32'(led), 32'h0000);
    cycles(10);
    chk("blink_on", 32'(led), 32'hA5A5);
    ndone = 0;
    for (int i = 0; i < 80; i++) begin
      cycle();
      if (done) ndone++;
    end
    chk("blink_no_done", 32'(ndone), 32'h0);
    chk("blink_busy", 32'(busy), 32'h1);

    // Abort: ROTR, two steps, then SOLID one step
    offer(3, 16'h8000, 28'd3, 8'd5);
    cycles(6);
    chk("rotr_two_steps", 32'(led), 32'h2000);
    offer(0, 16'hFFFF, 28'd2, 8'd1);
    chk("abort_led", 32'({done, led}), 32'h0_FFFF);
    cycles(1);
    chk("abort_no_done", 32'(done), 32'h0);
    cycles(1);
    chk("abort_done", 32'({done, step_tick, led}), 32'h3_FFFF);
    cycles(2);

    // Collision of accept and step edge, then reset mid-run
    offer(2, 16'h0003, 28'd4, 8'd0);
    cycles(3);
    offer(3, 16'h00F0, 28'd1, 8'd0);
    chk("collide", 32'({step_tick, led}), 32'h0_00F0);
    cycles(3);
    chk("per1_rotr", 32'(led), 32'h001E);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrun_reset", 32'({busy, led}), 32'h0_0000);
    cycles(2);

`ifdef LED_SEQ_PAUSE_EN
    // Pause for 7 cycles starting at accept+2
    offer(2, 16'h0001, 28'd4, 8'd2);
    cycles(1);
    pause = 1'b1;
    cycles(7);
    pause = 1'b0;
    cycles(2);
    chk("pause_no_tick_yet", 32'(step_tick), 32'h0);
    cycles(1);
    chk("pause_first_step", 32'({step_tick, led}), 32'h1_0002);
    cycles(6);
`endif

    // Randomized traffic against the model
    for (int t = 0; t < 1500; t++) begin
      rst       = ($urandom_range(0, 199) == 0);
      cfg_valid = ($urandom_range(0, 24) == 0);
      cfg_mode  = 2'($urandom_range(0, 3));
      cfg_pattern = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      cfg_period  = ($urandom_range(0, 5) == 0) ? 28'd0 : 28'($urandom_range(1, 6));
      cfg_count   = 8'($urandom_range(0, 4));
`ifdef LED_SEQ_PAUSE_EN
      pause = ($urandom_range(0, 5) == 0);
`endif
      cycle();
    end
    rst = 1'b0; cfg_valid = 1'b0; pause = 1'b0;
    cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
